// File: rtl/adder_share_ctrl.sv
// Round-robin controller that shares a single 32-bit ripple-carry adder
// among N_REQ requesters. It latches the winner's operands onto the adder
// inputs and holds them for SETTLE_CYCLES clocks. It then captures the sum
// and returns it together with the winner's index.
module adder_share_ctrl #(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    localparam int unsigned IW           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   op_a,
    input  logic [32*N_REQ-1:0]   op_b,
    output logic [N_REQ-1:0]      gnt,
    output logic                  done,
    output logic [IW-1:0]         done_id,
    output logic [31:0]           result,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    input  logic [31:0]           add_s
);

    localparam int unsigned DW = 32;
    // cnt only ever holds SETTLE_CYCLES-1 down to 0
    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] winner;
    logic [CW-1:0] cnt;

    logic          arb_hit_c;
    logic [IW-1:0] arb_idx_c;
    logic [DW-1:0] arb_a_c;
    logic [DW-1:0] arb_b_c;
    int unsigned   scan_idx_c;

    logic [DW-1:0] op_a_arr [N_REQ];
    logic [DW-1:0] op_b_arr [N_REQ];

    // Unpack the flat operand buses into per-requester words
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign op_a_arr[g] = op_a[DW*g +: DW];
        assign op_b_arr[g] = op_b[DW*g +: DW];
    end

    // Round-robin search: first asserted request at or after rr_ptr
    always_comb begin
        arb_hit_c  = 1'b0;
        arb_idx_c  = '0;
        arb_a_c    = '0;
        arb_b_c    = '0;
        scan_idx_c = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx_c = 32'(rr_ptr) + i;
            if (scan_idx_c >= N_REQ) begin
                scan_idx_c = scan_idx_c - N_REQ;
            end
            if (!arb_hit_c && req[IW'(scan_idx_c)]) begin
                arb_hit_c = 1'b1;
                arb_idx_c = IW'(scan_idx_c);
                arb_a_c   = op_a_arr[IW'(scan_idx_c)];
                arb_b_c   = op_b_arr[IW'(scan_idx_c)];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_hit_c) state_nxt = SETTLE;
            SETTLE:  if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs; operands stay on the adder after DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            result  <= '0;
            add_a   <= '0;
            add_b   <= '0;
            cnt     <= '0;
            rr_ptr  <= '0;
            winner  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_hit_c) begin
                        add_a  <= arb_a_c;
                        add_b  <= arb_b_c;
                        gnt    <= N_REQ'(1) << arb_idx_c;
                        winner <= arb_idx_c;
                        cnt    <= CW'(SETTLE_CYCLES - 1);
                    end
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        result  <= add_s;
                        done_id <= winner;
                        done    <= 1'b1;
                        gnt     <= '0;
                        rr_ptr  <= (winner == IW'(N_REQ - 1)) ? '0 : winner + IW'(1);
                    end
                end
                DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule
